// File: rtl/decode_stage.sv
// Decode stage of the 8-bit pipeline: IF/ID register, 8x8 register file with
// write-through bypass, jump resolution, and the ID/EX register feeding execute.
module decode_stage (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] PC,
  input  logic [7:0] Instruction_Code,
  input  logic       if_valid,
  input  logic       stall,
  input  logic       flush,
  input  logic       wb_en,
  input  logic [2:0] wb_addr,
  input  logic [7:0] wb_data,
  output logic       id_valid,
  output logic [1:0] id_opcode,
  output logic [2:0] id_rd,
  output logic [7:0] id_rd_data,
  output logic [7:0] id_rs_data,
  output logic [7:0] id_pc,
  output logic       jump_taken,
  output logic [7:0] jump_target
);

  typedef enum logic [1:0] {
    OP_MOV = 2'b00,
    OP_ADD = 2'b01,
    OP_SUB = 2'b10,
    OP_J   = 2'b11
  } opcode_t;

  logic       ifid_valid;
  logic [7:0] ifid_instr;
  logic [7:0] ifid_pc;

  logic [7:0] rf [8];

  opcode_t    dec_op;
  logic [2:0] dec_rd;
  logic [2:0] dec_rs;
  logic [7:0] rd_val;
  logic [7:0] rs_val;
  logic [7:0] off_ext;

  assign dec_op  = opcode_t'(ifid_instr[7:6]);
  assign dec_rd  = ifid_instr[5:3];
  assign dec_rs  = ifid_instr[2:0];
  assign off_ext = {{2{ifid_instr[5]}}, ifid_instr[5:0]};

  // Same-cycle write-back is forwarded so decode never reads a stale register.
  always_comb begin
    rd_val = rf[dec_rd];
    rs_val = rf[dec_rs];
    if (wb_en && (wb_addr == dec_rd)) rd_val = wb_data;
    if (wb_en && (wb_addr == dec_rs)) rs_val = wb_data;
  end

  assign jump_taken  = ifid_valid && (dec_op == OP_J) && !stall && !flush;
  assign jump_target = ifid_pc + 8'd1 + off_ext;

  always_ff @(posedge clk) begin
    if (reset) begin
      ifid_valid <= 1'b0;
      ifid_instr <= '0;
      ifid_pc    <= '0;
    end else if (flush || jump_taken) begin
      ifid_valid <= 1'b0;
    end else if (!stall) begin
      ifid_valid <= if_valid;
      ifid_instr <= Instruction_Code;
      ifid_pc    <= PC;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      id_valid   <= 1'b0;
      id_opcode  <= '0;
      id_rd      <= '0;
      id_rd_data <= '0;
      id_rs_data <= '0;
      id_pc      <= '0;
    end else if (flush || stall) begin
      id_valid   <= 1'b0;
    end else begin
      id_valid   <= ifid_valid;
      id_opcode  <= dec_op;
      id_rd      <= dec_rd;
      id_rd_data <= rd_val;
      id_rs_data <= rs_val;
      id_pc      <= ifid_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < 8; i++) rf[i] <= 8'(i);
    end else if (wb_en) begin
      rf[wb_addr] <= wb_data;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: a transaction-level model predicts each
// instruction leaving decode; a monitor compares whatever the DUT presents.
module tb_decode_stage;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] PC = '0;
  logic [7:0] Instruction_Code = '0;
  logic       if_valid = 1'b0;
  logic       stall = 1'b0;
  logic       flush = 1'b0;
  logic       wb_en = 1'b0;
  logic [2:0] wb_addr = '0;
  logic [7:0] wb_data = '0;
  logic       id_valid;
  logic [1:0] id_opcode;
  logic [2:0] id_rd;
  logic [7:0] id_rd_data;
  logic [7:0] id_rs_data;
  logic [7:0] id_pc;
  logic       jump_taken;
  logic [7:0] jump_target;

  decode_stage dut (
    .clk(clk), .reset(reset), .PC(PC), .Instruction_Code(Instruction_Code),
    .if_valid(if_valid), .stall(stall), .flush(flush),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .id_valid(id_valid), .id_opcode(id_opcode), .id_rd(id_rd),
    .id_rd_data(id_rd_data), .id_rs_data(id_rs_data), .id_pc(id_pc),
    .jump_taken(jump_taken), .jump_target(jump_target)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         due;
    logic [1:0] op;
    logic [2:0] rd;
    logic [7:0] rdd;
    logic [7:0] rsd;
    logic [7:0] pc;
  } exp_t;

  exp_t       sb[$];
  int         cyc = 0;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         known = 0;
  bit         chk_zero = 0;
  bit         done = 0;

  // Model state: the instruction waiting in decode and the architectural registers.
  bit         slot_v = 0;
  logic [7:0] slot_i = '0;
  logic [7:0] slot_pc = '0;
  logic [7:0] mrf [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] rd_reg(input logic [2:0] idx, input logic we,
                                        input logic [2:0] wa, input logic [7:0] wd);
    return (we && wa == idx) ? wd : mrf[idx];
  endfunction

  task automatic step(input logic rst, input logic iv, input logic [7:0] code,
                      input logic [7:0] pc, input logic st, input logic fl,
                      input logic we, input logic [2:0] wa, input logic [7:0] wd);
    bit         jt;
    int         off;
    logic [7:0] tgt;
    exp_t       e;
    @(negedge clk);
    if (chk_zero) begin
      chk("rst_id_valid", 32'(id_valid), 0);
      chk("rst_id_opcode", 32'(id_opcode), 0);
      chk("rst_id_rd", 32'(id_rd), 0);
      chk("rst_id_rd_data", 32'(id_rd_data), 0);
      chk("rst_id_rs_data", 32'(id_rs_data), 0);
      chk("rst_id_pc", 32'(id_pc), 0);
      chk_zero = 0;
    end
    reset = rst; if_valid = iv; Instruction_Code = code; PC = pc;
    stall = st; flush = fl; wb_en = we; wb_addr = wa; wb_data = wd;
    #1;
    jt  = slot_v && (slot_i[7:6] == 2'b11) && !st && !fl;
    off = int'(slot_i[5:0]);
    if (off >= 32) off -= 64;
    tgt = 8'((int'(slot_pc) + 1 + off) & 255);
    if (known) begin
      chk("jump_taken", 32'(jump_taken), 32'(jt));
      chk("jump_target", 32'(jump_target), 32'(tgt));
    end
    if (rst) begin
      slot_v = 0; slot_i = '0; slot_pc = '0;
      for (int i = 0; i < 8; i++) mrf[i] = 8'(i);
      chk_zero = 1;
      known = 1;
    end else begin
      if (slot_v && !st && !fl) begin
        e.due = cyc + 1;
        e.op  = slot_i[7:6];
        e.rd  = slot_i[5:3];
        e.rdd = rd_reg(slot_i[5:3], we, wa, wd);
        e.rsd = rd_reg(slot_i[2:0], we, wa, wd);
        e.pc  = slot_pc;
        sb.push_back(e);
      end
      if (fl || jt) slot_v = 0;
      else if (!st) begin slot_v = iv; slot_i = code; slot_pc = pc; end
      if (we) mrf[wa] = wd;
    end
  endtask

  task automatic idle(input logic st = 1'b0, input logic fl = 1'b0);
    step(1'b0, 1'b0, 8'h00, 8'h00, st, fl, 1'b0, 3'd0, 8'h00);
  endtask

  task automatic issue(input logic [7:0] code, input logic [7:0] pc);
    step(1'b0, 1'b1, code, pc, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
  endtask

  task automatic peek;
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops an expectation whenever ID/EX presents a valid instruction.
  initial begin
    exp_t e;
    while (!done) begin
      @(negedge clk);
      if (known && !done) begin
        if (sb.size() > 0 && sb[0].due < cyc) begin
          e = sb.pop_front();
          chk("missing_id_valid", 32'(id_valid), 1);
        end
        if (id_valid === 1'b1) begin
          if (sb.size() == 0) chk("unexpected_id_valid", 32'(id_valid), 0);
          else begin
            e = sb.pop_front();
            chk("sb_due", 32'(cyc), 32'(e.due));
            chk("sb_opcode", 32'(id_opcode), 32'(e.op));
            chk("sb_rd", 32'(id_rd), 32'(e.rd));
            chk("sb_rd_data", 32'(id_rd_data), 32'(e.rdd));
            chk("sb_rs_data", 32'(id_rs_data), 32'(e.rsd));
            chk("sb_pc", 32'(id_pc), 32'(e.pc));
          end
        end else if (id_valid !== 1'b0) begin
          chk("id_valid_known", 32'(id_valid), 0);
        end
      end
    end
  end

  initial begin
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);
    step(1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 8'h00);

    // ADD R1,R2 at PC 05
    issue(8'h4A, 8'h05);
    idle();
    peek();
    chk("add_valid", 32'(id_valid), 1);
    chk("add_opcode", 32'(id_opcode), 1);
    chk("add_rd", 32'(id_rd), 1);
    chk("add_rd_data", 32'(id_rd_data), 1);
    chk("add_rs_data", 32'(id_rs_data), 2);
    chk("add_pc", 32'(id_pc), 5);

    // Bypass: MOV R1,R3 while R3 is being written
    issue(8'h0B, 8'h06);
    step(1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 3'd3, 8'hA5);
    peek();
    chk("bypass_rs_data", 32'(id_rs_data), 32'hA5);
    issue(8'h03, 8'h07);
    idle();
    peek();
    chk("r3_after_write", 32'(id_rs_data), 32'hA5);

    // Jump -2 at PC 10, wrong-path instruction behind it
    issue(8'hFE, 8'h10);
    issue(8'h4A, 8'h11);
    chk("jump_taken_fe", 32'(jump_taken), 1);
    chk("jump_target_fe", 32'(jump_target), 32'h0F);
    idle();
    chk("jump_one_cycle", 32'(jump_taken), 0);
    chk("j_in_idex_opcode", 32'(id_opcode), 3);
    peek();
    chk("wrong_path_bubble", 32'(id_valid), 0);

    // Stall three cycles with ADD held in IF/ID
    issue(8'h4A, 8'h20);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, 8'h55, 8'h99, 1'b1, 1'b0, 1'b0, 3'd0, 8'h00);
      peek();
      chk("stall_bubble", 32'(id_valid), 0);
    end
    idle();
    peek();
    chk("stall_release_valid", 32'(id_valid), 1);
    chk("stall_release_pc", 32'(id_pc), 32'h20);

    // Flush and stall together
    issue(8'h4A, 8'h30);
    step(1'b0, 1'b1, 8'h11, 8'h31, 1'b1, 1'b1, 1'b0, 3'd0, 8'h00);
    peek();
    chk("flush_stall_idex", 32'(id_valid), 0);
    idle();
    peek();
    chk("flush_stall_ifid", 32'(id_valid), 0);

    // Stalled jump that is then flushed never redirects
    issue(8'hC1, 8'h40);
    idle(1'b1, 1'b0);
    chk("stalled_jump", 32'(jump_taken), 0);
    idle(1'b0, 1'b1);
    chk("flushed_jump", 32'(jump_taken), 0);
    idle();
    chk("flushed_jump_gone", 32'(jump_taken), 0);

    // PC wrap
    issue(8'hC0, 8'hFF);
    idle();
    chk("wrap_taken", 32'(jump_taken), 1);
    chk("wrap_target", 32'(jump_target), 32'h00);

    // Reset mid-stream, write-back in the same cycle must lose
    issue(8'h4A, 8'h01);
    step(1'b1, 1'b1, 8'h4A, 8'h02, 1'b0, 1'b0, 1'b1, 3'd0, 8'hFF);
    issue(8'h18, 8'h03);
    idle();
    peek();
    chk("reset_r3", 32'(id_rd_data), 3);
    chk("reset_r0", 32'(id_rs_data), 0);

    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0), 1'($urandom), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 9) == 0),
           1'($urandom), 3'($urandom), 8'($urandom));
    end
    for (int i = 0; i < 3; i++) idle();
    @(negedge clk);
    #2;
    chk("scoreboard_drained", 32'(sb.size()), 0);
    done = 1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
